ps2_host_tx: RTL
================

// Module: ps2_host_tx
// PURPOSE
//   PS/2 host-to-device transmitter: sends one command byte (e.g. 8'hED set-LEDs,
//   8'hFF reset) to the keyboard over the bidirectional ps2c/ps2d lines. It is the
//   transmit counterpart of the PS/2 receive path. Its tx_idle output drives the
//   receiver's rx_en, so the receiver is disabled while a command is on the bus.
//   It checks the device acknowledge and reports success or failure as one-cycle ticks.
// PARAMETERS
//   INHIBIT_CYCLES  10000      clk cycles ps2c is held low for request-to-send (100 us @ 100 MHz)
//   TIMEOUT_CYCLES  2000000    watchdog from start of inhibit to ack (20 ms @ 100 MHz)
//   FILTER_LEN      8          ps2c glitch-filter depth, in clk samples
// PORTS
//   clk           in     1  system clock
//   reset         in     1  synchronous, active-high reset
//   wr_ps2        in     1  start request; sampled only while tx_idle=1
//   din           in     8  command byte; captured on the cycle wr_ps2 is accepted
//   ps2c          inout  1  PS/2 clock; driven only to 0, otherwise high-Z
//   ps2d          inout  1  PS/2 data; driven only to 0, otherwise high-Z
//   tx_idle       out    1  1 = no transaction in progress; connect to receiver rx_en
//   tx_done_tick  out    1  1-cycle pulse: frame sent and device acked (ack = 0)
//   tx_err_tick   out    1  1-cycle pulse: nack (ack = 1) or watchdog timeout
// BEHAVIOUR
//   - Reset (synchronous): state=idle, both lines high-Z, tx_idle=1, both ticks=0.
//     Clear counters and the filter (filter output = 1). A reset during any state
//     releases both lines on the next clk edge. No tick is issued for an aborted frame.
//   - ps2c filter: shift FILTER_LEN samples. Output goes to 1 when all samples are 1,
//     goes to 0 when all samples are 0, and holds otherwise. fall_edge = filtered 1->0.
//   - Frame: start 0, din[0..7] LSB first, odd parity p = ~^din, stop 1, then the device ack.
//   - FSM:
//     idle : tx_idle=1. If wr_ps2, latch {p,din} into a 9-bit shifter, clear the
//            counters, and go to rts. The request is accepted at most once per cycle.
//     rts  : drive ps2c=0 and ps2d=0 for exactly INHIBIT_CYCLES cycles, then go to start.
//     start: release ps2c and keep ps2d=0 (start bit). On fall_edge #1, drive
//            shifter[0] and go to data with bit count n=8.
//     data : ps2d = 0 when the current bit is 0, high-Z when it is 1. On each
//            fall_edge, shift right and decrement n. After fall_edge #9 parity is on
//            the bus; at n=0, the next fall_edge (#10) goes to stop.
//     stop : ps2d released (the stop bit reads 1 via pull-up). On fall_edge #11 sample
//            raw ps2d: 0 -> pulse tx_done_tick; 1 -> pulse tx_err_tick. Then go to wait_rel.
//     wait_rel: wait until filtered ps2c=1 and ps2d=1, then go to idle.
//   - Watchdog: a counter starts on entry to rts. If it reaches TIMEOUT_CYCLES before
//     the stop-state sample, release both lines, pulse tx_err_tick, and go to idle.
//   - Each accepted wr_ps2 produces exactly one tick (done xor err), unless reset aborts it.
//   - wr_ps2 while tx_idle=0 is ignored, not queued. din is sampled only on acceptance.
//   - tx_idle=0 from the cycle after acceptance until the cycle idle is re-entered.
//   - Ticks are registered outputs, high for exactly one clk.
// TESTING (sim params: INHIBIT_CYCLES=20, TIMEOUT_CYCLES=5000, FILTER_LEN=8;
//          keyboard BFM clocks at a 400-clk period and samples on rising ps2c)
//   1. din=8'hED, BFM acks -> BFM sees 0,1,0,1,1,0,1,1,1,p=1,stop=1; one tx_done_tick;
//      tx_err_tick stays 0; tx_idle returns to 1.
//   2. din=8'h07 -> bits 1,1,1,0,0,0,0,0, p=0; done tick. ps2c is held low for exactly
//      20 cycles in rts.
//   3. BFM leaves ps2d=1 at edge #11 (nack) -> exactly one tx_err_tick, no done tick,
//      both lines high-Z afterward.
//   4. BFM never clocks -> tx_err_tick at cycle 5000 after rts entry; ps2c/ps2d high-Z;
//      tx_idle=1.
//   5. wr_ps2 pulsed with din=8'hFF mid-frame of 8'hED -> BFM still receives 8'hED only;
//      one tick total.
//   6. reset asserted during data state -> next edge: lines high-Z, tx_idle=1, no ticks;
//      a new wr_ps2 (8'hF4) then completes normally.

Source files
------------

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, sends one command byte
// with odd parity, then checks the keyboard's acknowledge bit.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_ps2,
    input  logic [7:0] din,
    inout  wire        ps2c,
    inout  wire        ps2d,
    output logic       tx_idle,
    output logic       tx_done_tick,
    output logic       tx_err_tick
);

    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, RTS, START, DATA, STOP, WAIT_REL} state_t;

    state_t                state_reg, state_next;
    logic [IW-1:0]         inh_reg, inh_next;
    logic [WW-1:0]         wd_reg, wd_next;
    logic [3:0]            n_reg, n_next;
    logic [8:0]            b_reg, b_next;
    logic [FILTER_LEN-1:0] filt_reg;
    logic                  f_reg, f_next;
    logic                  done_reg, done_next;
    logic                  err_reg, err_next;
    logic                  fall_edge;
    logic                  timeout;
    logic                  c_low, d_low;

    // State and datapath registers; the ps2c filter shifts in a raw sample every clock
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            inh_reg   <= '0;
            wd_reg    <= '0;
            n_reg     <= '0;
            b_reg     <= '0;
            filt_reg  <= '1;
            f_reg     <= 1'b1;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            inh_reg   <= inh_next;
            wd_reg    <= wd_next;
            n_reg     <= n_next;
            b_reg     <= b_next;
            filt_reg  <= {ps2c, filt_reg[FILTER_LEN-1:1]};
            f_reg     <= f_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
        end
    end

    // Filtered clock only changes once the whole window agrees
    always_comb begin
        f_next = f_reg;
        if (&filt_reg)
            f_next = 1'b1;
        else if (~|filt_reg)
            f_next = 1'b0;
    end

    assign fall_edge = f_reg & ~f_next;
    assign timeout   = (wd_reg == WW'(TIMEOUT_CYCLES - 1));

    // Next-state logic; the watchdog overrides everything except the final ack sample
    always_comb begin
        state_next = state_reg;
        inh_next   = inh_reg;
        wd_next    = wd_reg;
        n_next     = n_reg;
        b_next     = b_reg;
        done_next  = 1'b0;
        err_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (wr_ps2) begin
                    b_next     = {~^din, din};
                    inh_next   = '0;
                    wd_next    = '0;
                    n_next     = '0;
                    state_next = RTS;
                end
            end
            RTS: begin
                wd_next = wd_reg + 1'b1;
                if (inh_reg == IW'(INHIBIT_CYCLES - 1))
                    state_next = START;
                else
                    inh_next = inh_reg + 1'b1;
            end
            START: begin
                wd_next = wd_reg + 1'b1;
                if (fall_edge) begin
                    n_next     = 4'd8;
                    state_next = DATA;
                end
            end
            DATA: begin
                wd_next = wd_reg + 1'b1;
                if (fall_edge) begin
                    if (n_reg == 4'd0) begin
                        state_next = STOP;
                    end else begin
                        b_next = {1'b0, b_reg[8:1]};
                        n_next = n_reg - 4'd1;
                    end
                end
            end
            STOP: begin
                wd_next = wd_reg + 1'b1;
                if (fall_edge) begin
                    if (!ps2d)
                        done_next = 1'b1;
                    else
                        err_next = 1'b1;
                    state_next = WAIT_REL;
                end
            end
            WAIT_REL: begin
                if (f_reg && ps2d)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (timeout && ((state_reg == RTS) || (state_reg == START) || (state_reg == DATA) ||
                        ((state_reg == STOP) && !fall_edge))) begin
            state_next = IDLE;
            done_next  = 1'b0;
            err_next   = 1'b1;
        end
    end

    // Open-drain line control: a line is either pulled to 0 or released
    always_comb begin
        c_low   = 1'b0;
        d_low   = 1'b0;
        tx_idle = 1'b0;
        case (state_reg)
            IDLE:  tx_idle = 1'b1;
            RTS: begin
                c_low = 1'b1;
                d_low = 1'b1;
            end
            START: d_low = 1'b1;
            DATA:  d_low = ~b_reg[0];
            default: begin
                c_low = 1'b0;
                d_low = 1'b0;
            end
        endcase
    end

    assign ps2c         = c_low ? 1'b0 : 1'bz;
    assign ps2d         = d_low ? 1'b0 : 1'bz;
    assign tx_done_tick = done_reg;
    assign tx_err_tick  = err_reg;

endmodule
